// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared types and sizing for the instruction-queue controller.
//   ibuf_state_e : controller FSM states
//   IBUF_DEPTH   : queue entries (power of 2)
//   IBUF_BUNDLE  : fetch slots per cycle
//   IBUF_DISP    : max dispatches per cycle
//   PTR_W/OCC_W  : pointer width and occupancy width (one extra bit to hold DEPTH)
package ibuf_pkg;

    localparam int IBUF_DEPTH  = 32;
    localparam int IBUF_BUNDLE = 8;
    localparam int IBUF_DISP   = 4;
    localparam int PTR_W       = $clog2(IBUF_DEPTH);
    localparam int OCC_W       = PTR_W + 1;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2,
        FLUSH  = 2'd3
    } ibuf_state_e;

endpackage

// File: rtl/ibuf_popcnt8.sv
// ibuf_popcnt8: population count of an 8-bit vector.
//   bits : input vector
//   cnt  : number of set bits, 0..8
module ibuf_popcnt8 (
    input  logic [7:0] bits,
    output logic [3:0] cnt
);

    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, bits[i]};
        end
    end

endmodule

// File: rtl/ibuf_ctrl.sv
// ibuf_ctrl: sequencing controller for the frontend/backend instruction queue.
// Tracks occupancy and read/write pointers, accepts fetch bundles, grants up to
// DISP_W dispatches per cycle against backend credit, and recovers from flush.
//   clock, reset_n : clock and synchronous active-low reset
//   flush_i        : pipeline redirect; clears the queue, then FLUSH_CYC dead cycles
//   fe_vld_i/mask  : fetch bundle and its contiguous slot valids
//   fe_rdy_o       : room for a full bundle
//   be_cred_i      : backend free slots (values above DISP_W clamp)
//   wr_en_o/ptr_o  : per-slot write enables and base write index
//   rd_ptr_o       : oldest entry index
//   disp_vld_o/cnt : granted dispatch lanes (thermometer) and their count
//   occ_o          : entries held
//   buf_full_o     : FSM in FULL
//   buf_empty_o    : no entries and not recovering from flush
module ibuf_ctrl
    import ibuf_pkg::*;
#(
    parameter int DEPTH     = IBUF_DEPTH,
    parameter int BUNDLE    = IBUF_BUNDLE,
    parameter int DISP_W    = IBUF_DISP,
    parameter int FLUSH_CYC = 1,
    localparam int PW       = $clog2(DEPTH),
    localparam int OW       = PW + 1,
    localparam int DCW      = $clog2(DISP_W + 1),
    localparam int FCW      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              fe_vld_i,
    input  logic [BUNDLE-1:0] fe_mask_i,
    output logic              fe_rdy_o,
    input  logic [2:0]        be_cred_i,
    output logic [BUNDLE-1:0] wr_en_o,
    output logic [PW-1:0]     wr_ptr_o,
    output logic [PW-1:0]     rd_ptr_o,
    output logic [DISP_W-1:0] disp_vld_o,
    output logic [DCW-1:0]    disp_cnt_o,
    output logic [OW-1:0]     occ_o,
    output logic              buf_full_o,
    output logic              buf_empty_o
);

    localparam logic [OW-1:0]  RDY_MAX  = OW'(DEPTH - BUNDLE);
    localparam logic [OW-1:0]  DISP_MAX = OW'(DISP_W);
    localparam logic [FCW-1:0] FC_LOAD  = FCW'(FLUSH_CYC - 1);

    ibuf_state_e    state, state_nx;
    logic [OW-1:0]  occ, occ_nx;
    logic [PW-1:0]  wr_ptr, wr_ptr_nx;
    logic [PW-1:0]  rd_ptr, rd_ptr_nx;
    logic [FCW-1:0] fcnt, fcnt_nx;

    logic           accept;
    logic [3:0]     pop;
    logic [OW-1:0]  wcnt;
    logic [OW-1:0]  cred;
    logic [OW-1:0]  disp;

    ibuf_popcnt8 u_pop (
        .bits (fe_mask_i),
        .cnt  (pop)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= EMPTY;
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            state  <= state_nx;
            occ    <= occ_nx;
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            fcnt   <= fcnt_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        fe_rdy_o   = 1'b0;
        accept     = 1'b0;
        wcnt       = '0;
        cred       = '0;
        disp       = '0;
        wr_en_o    = '0;
        disp_vld_o = '0;
        state_nx   = state;
        occ_nx     = occ;
        wr_ptr_nx  = wr_ptr;
        rd_ptr_nx  = rd_ptr;
        fcnt_nx    = fcnt;

        fe_rdy_o = ((state == EMPTY) || (state == ACTIVE)) && (occ <= RDY_MAX);

        // flush squashes the write and the dispatch of its own cycle
        accept = fe_vld_i && fe_rdy_o && !flush_i;
        if (accept) begin
            wcnt    = OW'(pop);
            wr_en_o = fe_mask_i;
        end

        // dispatch only from registered occupancy: no write->dispatch bypass
        cred = (OW'(be_cred_i) > DISP_MAX) ? DISP_MAX : OW'(be_cred_i);
        if (state != FLUSH && !flush_i) begin
            disp = (occ < cred) ? occ : cred;
        end
        for (int i = 0; i < DISP_W; i++) begin
            disp_vld_o[i] = (OW'(i) < disp);
        end

        if (flush_i) begin
            state_nx  = FLUSH;
            occ_nx    = '0;
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
            fcnt_nx   = FC_LOAD;
        end else if (state == FLUSH) begin
            // queue is already empty here; just count out the dead cycles
            if (fcnt == '0) begin
                state_nx = EMPTY;
            end else begin
                fcnt_nx = fcnt - 1'b1;
            end
        end else begin
            occ_nx    = occ + wcnt - disp;
            wr_ptr_nx = wr_ptr + PW'(wcnt);
            rd_ptr_nx = rd_ptr + PW'(disp);
            if (occ_nx == '0) begin
                state_nx = EMPTY;
            end else if (occ_nx <= RDY_MAX) begin
                state_nx = ACTIVE;
            end else begin
                state_nx = FULL;
            end
        end
    end

    assign disp_cnt_o  = DCW'(disp);
    assign wr_ptr_o    = wr_ptr;
    assign rd_ptr_o    = rd_ptr;
    assign occ_o       = occ;
    assign buf_full_o  = (state == FULL);
    assign buf_empty_o = (occ == '0) && (state != FLUSH);

    // Slot valids must be a run of ones from bit 0 (m & (m+1) == 0).
    always_ff @(posedge clock) begin
        if (reset_n && accept) begin
            assert ((fe_mask_i & (fe_mask_i + 1'b1)) == '0);
        end
    end

endmodule

// File: tb/tb_ibuf_ctrl.sv
// tb_ibuf_ctrl: directed self-checking bench for ibuf_ctrl.
// Inputs change 1 time unit after the rising edge; checks run after settling.
module tb_ibuf_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       flush_i;
    logic       fe_vld_i;
    logic [7:0] fe_mask_i;
    logic       fe_rdy_o;
    logic [2:0] be_cred_i;
    logic [7:0] wr_en_o;
    logic [4:0] wr_ptr_o;
    logic [4:0] rd_ptr_o;
    logic [3:0] disp_vld_o;
    logic [2:0] disp_cnt_o;
    logic [5:0] occ_o;
    logic       buf_full_o;
    logic       buf_empty_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    ibuf_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush_i     (flush_i),
        .fe_vld_i    (fe_vld_i),
        .fe_mask_i   (fe_mask_i),
        .fe_rdy_o    (fe_rdy_o),
        .be_cred_i   (be_cred_i),
        .wr_en_o     (wr_en_o),
        .wr_ptr_o    (wr_ptr_o),
        .rd_ptr_o    (rd_ptr_o),
        .disp_vld_o  (disp_vld_o),
        .disp_cnt_o  (disp_cnt_o),
        .occ_o       (occ_o),
        .buf_full_o  (buf_full_o),
        .buf_empty_o (buf_empty_o)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [7:0] mask, input logic [2:0] cred);
        fe_vld_i  = vld;
        fe_mask_i = mask;
        be_cred_i = cred;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush_i = 1'b0;
        fe_vld_i = 1'b0; fe_mask_i = 8'h00; be_cred_i = 3'd0;

        // reset held two cycles
        tick(); tick();
        chk("rst_occ",   occ_o, 0);
        chk("rst_wptr",  wr_ptr_o, 0);
        chk("rst_rptr",  rd_ptr_o, 0);
        chk("rst_rdy",   fe_rdy_o, 1);
        chk("rst_empty", buf_empty_o, 1);
        chk("rst_full",  buf_full_o, 0);
        chk("rst_dcnt",  disp_cnt_o, 0);
        chk("rst_dvld",  disp_vld_o, 0);
        reset_n = 1'b1;

        // fill with no credit: 3 bundles -> 24 ACTIVE, 4th -> 32 FULL
        drive(1'b1, 8'hFF, 3'd0);
        chk("fill_wren", wr_en_o, 8'hFF);
        tick(); tick(); tick();
        chk("fill24_occ",  occ_o, 24);
        chk("fill24_full", buf_full_o, 0);
        chk("fill24_rdy",  fe_rdy_o, 1);
        chk("fill24_wren", wr_en_o, 8'hFF);
        tick();
        chk("fill32_occ",  occ_o, 32);
        chk("fill32_full", buf_full_o, 1);
        chk("fill32_rdy",  fe_rdy_o, 0);
        chk("fill5_wren",  wr_en_o, 8'h00);
        tick();
        chk("fill5_occ",   occ_o, 32);
        chk("fill5_wptr",  wr_ptr_o, 0);

        // drain 7 x 4 -> occ 4, rd_ptr 28
        drive(1'b0, 8'h00, 3'd4);
        chk("drain_dcnt", disp_cnt_o, 4);
        chk("drain_dvld", disp_vld_o, 4'hF);
        repeat (7) tick();
        chk("drain_occ",  occ_o, 4);
        chk("drain_rptr", rd_ptr_o, 28);

        // bundle + 2 dispatches -> occ 10, wr 8, rd 30
        drive(1'b1, 8'hFF, 3'd2);
        tick();
        chk("mix_occ",  occ_o, 10);
        chk("mix_rptr", rd_ptr_o, 30);
        chk("mix_wptr", wr_ptr_o, 8);

        // credit 7 clamps to 4; rd_ptr wraps 30 -> 2
        drive(1'b0, 8'h00, 3'd7);
        chk("clamp_dcnt", disp_cnt_o, 4);
        chk("clamp_dvld", disp_vld_o, 4'hF);
        tick();
        chk("rwrap_rptr", rd_ptr_o, 2);
        chk("rwrap_occ",  occ_o, 6);

        // backpressure: 6 -> 3, then credit 2 at occ 3
        drive(1'b0, 8'h00, 3'd3);
        tick();
        chk("bp_occ3", occ_o, 3);
        drive(1'b0, 8'h00, 3'd2);
        chk("bp_dvld", disp_vld_o, 4'b0011);
        chk("bp_dcnt", disp_cnt_o, 2);
        tick();
        chk("bp_occ1", occ_o, 1);
        drive(1'b0, 8'h00, 3'd4);
        chk("occlim_dcnt", disp_cnt_o, 1);
        chk("occlim_dvld", disp_vld_o, 4'b0001);
        tick();
        chk("drain0_occ",   occ_o, 0);
        chk("drain0_empty", buf_empty_o, 1);
        chk("drain0_rptr",  rd_ptr_o, 8);

        // walk wr_ptr to 28: wr 8->16->24->28, rd 8->8->12->16
        drive(1'b1, 8'hFF, 3'd4);
        chk("nobypass_dcnt", disp_cnt_o, 0);
        tick();
        tick();
        drive(1'b1, 8'h0F, 3'd4);
        tick();
        chk("pre_wptr", wr_ptr_o, 28);
        chk("pre_occ",  occ_o, 12);

        // write wrap: 6 slots from 28 -> next wr_ptr 2
        drive(1'b1, 8'h3F, 3'd0);
        chk("wwrap_wren", wr_en_o, 8'h3F);
        chk("wwrap_wptr", wr_ptr_o, 28);
        tick();
        chk("wwrap_wptr2", wr_ptr_o, 2);
        chk("wwrap_occ",   occ_o, 18);

        // 18 + 6 -> 24, then full bundle + 4 dispatch -> 28 FULL
        tick();
        chk("sim_occ24", occ_o, 24);
        chk("sim_rdy",   fe_rdy_o, 1);
        drive(1'b1, 8'hFF, 3'd4);
        chk("sim_dcnt", disp_cnt_o, 4);
        chk("sim_wren", wr_en_o, 8'hFF);
        tick();
        chk("sim_occ28", occ_o, 28);
        chk("sim_full",  buf_full_o, 1);
        chk("sim_rdy28", fe_rdy_o, 0);

        // drain to 17
        drive(1'b0, 8'h00, 3'd4);
        tick(); tick();
        drive(1'b0, 8'h00, 3'd3);
        tick();
        chk("pf_occ",  occ_o, 17);
        chk("pf_rptr", rd_ptr_o, 31);
        chk("pf_wptr", wr_ptr_o, 16);

        // flush with a bundle and credit present
        flush_i = 1'b1;
        drive(1'b1, 8'hFF, 3'd4);
        chk("fl_wren", wr_en_o, 8'h00);
        chk("fl_dcnt", disp_cnt_o, 0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_occ",   occ_o, 0);
        chk("fl_wptr",  wr_ptr_o, 0);
        chk("fl_rptr",  rd_ptr_o, 0);
        chk("fl_rdy",   fe_rdy_o, 0);
        chk("fl_empty", buf_empty_o, 0);
        chk("fl_wren2", wr_en_o, 8'h00);
        tick();
        chk("flx_rdy",   fe_rdy_o, 1);
        chk("flx_empty", buf_empty_o, 1);
        chk("flx_wren",  wr_en_o, 8'hFF);
        tick();
        chk("flx_occ", occ_o, 8);

        // flush during FLUSH reloads the counter
        drive(1'b0, 8'h00, 3'd0);
        flush_i = 1'b1;
        tick();
        tick();
        flush_i = 1'b0;
        #1;
        chk("refl_rdy", fe_rdy_o, 0);
        tick();
        chk("refl_rdy2", fe_rdy_o, 1);

        // reset beats flush and skips recovery
        drive(1'b1, 8'h0F, 3'd0);
        tick();
        chk("mr_occ", occ_o, 4);
        reset_n = 1'b0;
        flush_i = 1'b1;
        tick();
        reset_n = 1'b1;
        flush_i = 1'b0;
        drive(1'b0, 8'h00, 3'd0);
        chk("mr_occ0",  occ_o, 0);
        chk("mr_wptr",  wr_ptr_o, 0);
        chk("mr_rdy",   fe_rdy_o, 1);
        chk("mr_empty", buf_empty_o, 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
